// File: rtl/chip8_sprite_engine.sv
// Purpose: DXYN sprite XOR-draw and 00E0 clear sequencer driving chip8 VRAM port A and program RAM reads.
// Latency: (2+RD_LAT)*rows + 1 cycles per draw (done in the last), 33 cycles per clear.
// Backpressure: none; start/clear are only sampled in IDLE and dropped otherwise, busy flags the window.
module chip8_sprite_engine #(
   parameter int RD_LAT = 1,
   parameter bit WRAP   = 1'b0
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        clear,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   input  logic [3:0]  n,
   input  logic [11:0] i_addr,
   output logic        busy,
   output logic        done,
   output logic        collision,
   output logic [11:0] ram_address,
   input  logic [7:0]  ram_q,
   output logic [4:0]  vram_address,
   output logic [63:0] vram_data,
   output logic        vram_wren,
   input  logic [63:0] vram_q
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_CLR, S_DONE} state_t;

   // RD_LAT must be at least 1: q is captured on the last WAIT cycle.
   localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_LAT - 1);

   state_t         state_q, state_d;
   logic [5:0]     col_q, col_d;
   logic [4:0]     row0_q, row0_d;
   logic [3:0]     n_q, n_d;
   logic [11:0]    base_q, base_d;
   logic [4:0]     r_q, r_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [4:0]     clr_cnt_q, clr_cnt_d;
   logic [7:0]     b_q, b_d;
   logic [63:0]    old_q, old_d;
   logic           coll_q, coll_d;

   logic [5:0]     row_sum;
   logic [5:0]     row_next_sum;
   logic [4:0]     r_inc;
   logic [63:0]    base_mask;
   logic [63:0]    mask;

   assign collision = coll_q;

   // Next-state and Moore outputs; addresses held through WAIT for the registered-address RAMs.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row0_d       = row0_q;
      n_d          = n_q;
      base_d       = base_q;
      r_d          = r_q;
      wcnt_d       = wcnt_q;
      clr_cnt_d    = clr_cnt_q;
      b_d          = b_q;
      old_d        = old_q;
      coll_d       = coll_q;
      busy         = 1'b0;
      done         = 1'b0;
      ram_address  = 12'd0;
      vram_address = 5'd0;
      vram_data    = 64'd0;
      vram_wren    = 1'b0;

      // Row index without wrap; bit 5 set means the row fell off the bottom.
      row_sum      = 6'(row0_q) + 6'(r_q);
      r_inc        = r_q + 5'd1;
      row_next_sum = 6'(row0_q) + 6'(r_inc);

      // Bit 63 is column 0, so the sprite byte starts at the top and slides right by col.
      base_mask = {b_q, 56'd0};
      if (WRAP)
         mask = (base_mask >> col_q) | (base_mask << (7'd64 - {1'b0, col_q}));
      else
         mask = base_mask >> col_q;

      case (state_q)
         S_IDLE: begin
            if (clear) begin
               clr_cnt_d = 5'd0;
               coll_d    = 1'b0;
               state_d   = S_CLR;
            end else if (start) begin
               col_d   = x[5:0];
               row0_d  = y[4:0];
               n_d     = n;
               base_d  = i_addr;
               r_d     = 5'd0;
               coll_d  = 1'b0;
               state_d = (n == 4'd0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            busy         = 1'b1;
            ram_address  = base_q + 12'(r_q);
            vram_address = row_sum[4:0];
            wcnt_d       = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            busy         = 1'b1;
            ram_address  = base_q + 12'(r_q);
            vram_address = row_sum[4:0];
            if (wcnt_q == WAIT_LAST) begin
               b_d     = ram_q;
               old_d   = vram_q;
               state_d = S_WRITE;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         S_WRITE: begin
            busy         = 1'b1;
            vram_wren    = 1'b1;
            vram_address = row_sum[4:0];
            vram_data    = old_q ^ mask;
            coll_d       = coll_q | (|(old_q & mask));
            r_d          = r_inc;
            if ((r_inc == {1'b0, n_q}) || (!WRAP && (row_next_sum > 6'd31)))
               state_d = S_DONE;
            else
               state_d = S_ISSUE;
         end
         S_CLR: begin
            busy         = 1'b1;
            vram_wren    = 1'b1;
            vram_address = clr_cnt_q;
            if (clr_cnt_q == 5'd31)
               state_d = S_DONE;
            else
               clr_cnt_d = clr_cnt_q + 5'd1;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= S_IDLE;
         col_q     <= 6'd0;
         row0_q    <= 5'd0;
         n_q       <= 4'd0;
         base_q    <= 12'd0;
         r_q       <= 5'd0;
         wcnt_q    <= '0;
         clr_cnt_q <= 5'd0;
         b_q       <= 8'd0;
         old_q     <= 64'd0;
         coll_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row0_q    <= row0_d;
         n_q       <= n_d;
         base_q    <= base_d;
         r_q       <= r_d;
         wcnt_q    <= wcnt_d;
         clr_cnt_q <= clr_cnt_d;
         b_q       <= b_d;
         old_q     <= old_d;
         coll_q    <= coll_d;
      end
   end

endmodule

// File: tb/tb_chip8_sprite_engine.sv
// Bench for chip8_sprite_engine: clipped and wrapping instances side by side on shared stimulus.
// Each instance has its own registered-address VRAM model; program RAM is shared and read-only.
// Results sampled 1 time unit after the rising edge.
module tb_chip8_sprite_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic [7:0]  x = 8'd0;
   logic [7:0]  y = 8'd0;
   logic [3:0]  n = 4'd0;
   logic [11:0] i_addr = 12'd0;

   logic        busy0, done0, coll0, wren0;
   logic [11:0] ram_addr0;
   logic [7:0]  ram_q0;
   logic [4:0]  vaddr0;
   logic [63:0] vdata0, vram_q0;
   logic        busy1, done1, coll1, wren1;
   logic [11:0] ram_addr1;
   logic [7:0]  ram_q1;
   logic [4:0]  vaddr1;
   logic [63:0] vdata1, vram_q1;

   logic [7:0]  ram   [0:4095];
   logic [63:0] vram0 [0:31];
   logic [63:0] vram1 [0:31];

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   chip8_sprite_engine #(.RD_LAT(1), .WRAP(1'b0)) dut0 (
      .CLOCK_50(clk), .reset(reset), .start(start), .clear(clear),
      .x(x), .y(y), .n(n), .i_addr(i_addr),
      .busy(busy0), .done(done0), .collision(coll0),
      .ram_address(ram_addr0), .ram_q(ram_q0),
      .vram_address(vaddr0), .vram_data(vdata0), .vram_wren(wren0), .vram_q(vram_q0)
   );

   chip8_sprite_engine #(.RD_LAT(1), .WRAP(1'b1)) dut1 (
      .CLOCK_50(clk), .reset(reset), .start(start), .clear(clear),
      .x(x), .y(y), .n(n), .i_addr(i_addr),
      .busy(busy1), .done(done1), .collision(coll1),
      .ram_address(ram_addr1), .ram_q(ram_q1),
      .vram_address(vaddr1), .vram_data(vdata1), .vram_wren(wren1), .vram_q(vram_q1)
   );

   // Synchronous RAMs with registered address: q follows the address one edge later.
   always @(posedge clk) begin
      ram_q0 <= ram[ram_addr0];
      ram_q1 <= ram[ram_addr1];
      if (wren0) vram0[vaddr0] <= vdata0;
      if (wren1) vram1[vaddr1] <= vdata1;
      vram_q0 <= vram0[vaddr0];
      vram_q1 <= vram1[vaddr1];
   end

   // Present a request for one edge; returns at cycle 1 (1 unit after the accepting edge).
   task automatic launch(input bit strt, input bit clr, input logic [7:0] xx, input logic [7:0] yy,
                         input logic [3:0] nn, input logic [11:0] ii);
      @(negedge clk);
      x = xx; y = yy; n = nn; i_addr = ii;
      start = strt; clear = clr;
      @(posedge clk); #1;
      start = 1'b0; clear = 1'b0;
   endtask

   // Run one operation on both instances, recording done cycle, write count and rows written.
   // pokes[k] re-pulses start (with other coordinates) during cycle k.
   task automatic run_op(input bit strt, input bit clr, input logic [7:0] xx, input logic [7:0] yy,
                         input logic [3:0] nn, input logic [11:0] ii, input logic [63:0] pokes,
                         output int d0, output int d1, output int w0, output int w1,
                         output logic [31:0] rows0, output logic [31:0] rows1, output bit nz);
      d0 = -1; d1 = -1; w0 = 0; w1 = 0; rows0 = '0; rows1 = '0; nz = 1'b0;
      launch(strt, clr, xx, yy, nn, ii);
      for (int k = 1; k <= 200; k++) begin
         if (done0 && d0 < 0) d0 = k;
         if (done1 && d1 < 0) d1 = k;
         if (wren0) begin
            w0++;
            rows0[vaddr0] = 1'b1;
            if (clr && vdata0 != 64'd0) nz = 1'b1;
         end
         if (wren1) begin
            w1++;
            rows1[vaddr1] = 1'b1;
            if (clr && vdata1 != 64'd0) nz = 1'b1;
         end
         if (k < 64 && pokes[k]) begin
            start = 1'b1; x = 8'd40; y = 8'd20;
         end else begin
            start = 1'b0;
         end
         if (d0 > 0 && d1 > 0) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b want 0", busy0); else pass_cnt++;
      total_cnt++; if (done0 !== 1'b0) $display("FAIL reset_done0: got %b want 0", done0); else pass_cnt++;
      total_cnt++; if (wren0 !== 1'b0) $display("FAIL reset_wren0: got %b want 0", wren0); else pass_cnt++;
      total_cnt++; if (coll0 !== 1'b0) $display("FAIL reset_coll0: got %b want 0", coll0); else pass_cnt++;
      total_cnt++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b want 0", busy1); else pass_cnt++;
      total_cnt++; if (vaddr0 !== 5'd0 || ram_addr0 !== 12'd0 || vdata0 !== 64'd0)
         $display("FAIL reset_addr0: got ram %h vram %h data %h want 0", ram_addr0, vaddr0, vdata0);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_clear();
      int d0, d1, w0, w1;
      logic [31:0] r0, r1;
      bit nz;
      // start raised together with clear: clear must win
      run_op(1'b1, 1'b1, 8'd5, 8'd5, 4'd3, 12'h050, 64'd0, d0, d1, w0, w1, r0, r1, nz);
      total_cnt++; if (d0 !== 33) $display("FAIL clear_done0: got cycle %0d want 33", d0); else pass_cnt++;
      total_cnt++; if (d1 !== 33) $display("FAIL clear_done1: got cycle %0d want 33", d1); else pass_cnt++;
      total_cnt++; if (w0 !== 32) $display("FAIL clear_wren0: got %0d want 32", w0); else pass_cnt++;
      total_cnt++; if (w1 !== 32) $display("FAIL clear_wren1: got %0d want 32", w1); else pass_cnt++;
      total_cnt++; if (r0 !== 32'hFFFF_FFFF) $display("FAIL clear_rows0: got %h want ffffffff", r0); else pass_cnt++;
      total_cnt++; if (nz !== 1'b0) $display("FAIL clear_data: got nonzero write want all zero"); else pass_cnt++;
      total_cnt++; if (vram0[17] !== 64'd0) $display("FAIL clear_row17: got %h want 0", vram0[17]); else pass_cnt++;
   endtask

   task automatic test_draw_basic();
      int d0, d1, w0, w1;
      logic [31:0] r0, r1;
      bit nz;
      run_op(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h050, 64'd0, d0, d1, w0, w1, r0, r1, nz);
      total_cnt++; if (d0 !== 4) $display("FAIL draw_done0: got cycle %0d want 4", d0); else pass_cnt++;
      total_cnt++; if (d1 !== 4) $display("FAIL draw_done1: got cycle %0d want 4", d1); else pass_cnt++;
      total_cnt++; if (vram0[0] !== 64'hF000_0000_0000_0000) $display("FAIL draw_row0_w0: got %h want f000000000000000", vram0[0]); else pass_cnt++;
      total_cnt++; if (vram1[0] !== 64'hF000_0000_0000_0000) $display("FAIL draw_row0_w1: got %h want f000000000000000", vram1[0]); else pass_cnt++;
      total_cnt++; if (coll0 !== 1'b0) $display("FAIL draw_coll0: got %b want 0", coll0); else pass_cnt++;
   endtask

   task automatic test_redraw();
      int d0, d1, w0, w1;
      logic [31:0] r0, r1;
      bit nz;
      run_op(1'b1, 1'b0, 8'd0, 8'd0, 4'd1, 12'h050, 64'd0, d0, d1, w0, w1, r0, r1, nz);
      total_cnt++; if (vram0[0] !== 64'd0) $display("FAIL redraw_row0: got %h want 0", vram0[0]); else pass_cnt++;
      total_cnt++; if (coll0 !== 1'b1) $display("FAIL redraw_coll0: got %b want 1", coll0); else pass_cnt++;
      total_cnt++; if (coll1 !== 1'b1) $display("FAIL redraw_coll1: got %b want 1", coll1); else pass_cnt++;
   endtask

   task automatic test_hclip();
      int d0, d1, w0, w1;
      logic [31:0] r0, r1;
      bit nz;
      run_op(1'b1, 1'b0, 8'd60, 8'd3, 4'd1, 12'h060, 64'd0, d0, d1, w0, w1, r0, r1, nz);
      total_cnt++; if (vram0[3] !== 64'h0000_0000_0000_000F) $display("FAIL hclip_clip: got %h want 000000000000000f", vram0[3]); else pass_cnt++;
      total_cnt++; if (vram1[3] !== 64'hF000_0000_0000_000F) $display("FAIL hclip_wrap: got %h want f00000000000000f", vram1[3]); else pass_cnt++;
      total_cnt++; if (coll0 !== 1'b0) $display("FAIL hclip_coll0: got %b want 0", coll0); else pass_cnt++;
   endtask

   task automatic test_vclip();
      int d0, d1, w0, w1;
      logic [31:0] r0, r1;
      bit nz;
      run_op(1'b1, 1'b0, 8'd8, 8'd30, 4'd5, 12'h070, 64'd0, d0, d1, w0, w1, r0, r1, nz);
      total_cnt++; if (w0 !== 2) $display("FAIL vclip_wren0: got %0d want 2", w0); else pass_cnt++;
      total_cnt++; if (r0 !== 32'hC000_0000) $display("FAIL vclip_rows0: got %h want c0000000", r0); else pass_cnt++;
      total_cnt++; if (d0 !== 7) $display("FAIL vclip_done0: got cycle %0d want 7", d0); else pass_cnt++;
      total_cnt++; if (w1 !== 5) $display("FAIL vclip_wren1: got %0d want 5", w1); else pass_cnt++;
      total_cnt++; if (r1 !== 32'hC000_0007) $display("FAIL vclip_rows1: got %h want c0000007", r1); else pass_cnt++;
      total_cnt++; if (d1 !== 16) $display("FAIL vclip_done1: got cycle %0d want 16", d1); else pass_cnt++;
      total_cnt++; if (vram0[31] !== 64'h0040_0000_0000_0000) $display("FAIL vclip_row31_w0: got %h want 0040000000000000", vram0[31]); else pass_cnt++;
      total_cnt++; if (vram0[0] !== 64'd0) $display("FAIL vclip_row0_w0: got %h want 0", vram0[0]); else pass_cnt++;
      total_cnt++; if (vram1[0] !== 64'h0020_0000_0000_0000) $display("FAIL vclip_row0_w1: got %h want 0020000000000000", vram1[0]); else pass_cnt++;
      total_cnt++; if (vram1[2] !== 64'h0008_0000_0000_0000) $display("FAIL vclip_row2_w1: got %h want 0008000000000000", vram1[2]); else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      int d0, d1, w0, w1;
      logic [31:0] r0, r1;
      bit nz;
      // x=80 -> column 16, y=42 -> row 10; start re-pulsed in WRITE (cycle 3) and DONE (cycle 7)
      run_op(1'b1, 1'b0, 8'd80, 8'd42, 4'd2, 12'h050, 64'h88, d0, d1, w0, w1, r0, r1, nz);
      total_cnt++; if (d0 !== 7) $display("FAIL busy_done0: got cycle %0d want 7", d0); else pass_cnt++;
      total_cnt++; if (w0 !== 2) $display("FAIL busy_wren0: got %0d want 2", w0); else pass_cnt++;
      total_cnt++; if (r1 !== 32'h0000_0C00) $display("FAIL busy_rows1: got %h want 00000c00", r1); else pass_cnt++;
      total_cnt++; if (vram0[10] !== 64'h0000_F000_0000_0000) $display("FAIL busy_row10: got %h want 0000f00000000000", vram0[10]); else pass_cnt++;
      total_cnt++; if (vram1[11] !== 64'h0000_0F00_0000_0000) $display("FAIL busy_row11: got %h want 00000f0000000000", vram1[11]); else pass_cnt++;
      total_cnt++; if (vram0[20] !== 64'd0) $display("FAIL busy_row20: got %h want 0", vram0[20]); else pass_cnt++;
      total_cnt++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL busy_after: got %b%b want 00", busy0, busy1); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      launch(1'b1, 1'b0, 8'd0, 8'd20, 4'd4, 12'h080);
      repeat (6) @(posedge clk);
      #1;
      // cycle 7: ISSUE of the third row
      reset = 1'b1;
      @(posedge clk); #1;
      total_cnt++; if (wren0 !== 1'b0 || wren1 !== 1'b0) $display("FAIL rstmid_wren: got %b%b want 00", wren0, wren1); else pass_cnt++;
      total_cnt++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL rstmid_busy: got %b%b want 00", busy0, busy1); else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      total_cnt++; if (busy0 !== 1'b0) $display("FAIL rstmid_idle: got busy %b want 0", busy0); else pass_cnt++;
      total_cnt++; if (vram0[20] !== 64'hAA00_0000_0000_0000) $display("FAIL rstmid_row20: got %h want aa00000000000000", vram0[20]); else pass_cnt++;
      total_cnt++; if (vram1[21] !== 64'h5500_0000_0000_0000) $display("FAIL rstmid_row21: got %h want 5500000000000000", vram1[21]); else pass_cnt++;
      total_cnt++; if (vram0[22] !== 64'd0) $display("FAIL rstmid_row22: got %h want 0", vram0[22]); else pass_cnt++;
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) ram[a] = 8'h00;
      ram[12'h050] = 8'hF0;
      ram[12'h051] = 8'h0F;
      ram[12'h060] = 8'hFF;
      ram[12'h070] = 8'h80;
      ram[12'h071] = 8'h40;
      ram[12'h072] = 8'h20;
      ram[12'h073] = 8'h10;
      ram[12'h074] = 8'h08;
      ram[12'h080] = 8'hAA;
      ram[12'h081] = 8'h55;
      ram[12'h082] = 8'hAA;
      ram[12'h083] = 8'h55;

      test_reset();
      test_clear();
      test_draw_basic();
      test_redraw();
      test_hclip();
      test_vclip();
      test_busy_ignore();
      test_reset_mid();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
